spi_addr_peripheral: RTL and testbench

- SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) that runs entirely in the sys_clk domain; pad signals are oversampled and synchronised.
- Within each chip-select frame, the first received byte is the address and every later byte is data.
- Provides a per-byte handshake so user logic can supply the next byte to shift out on MISO.
- Sits between the FPGA SPI pads and register/loopback logic.

---
 rtl/spi_addr_peripheral.sv | 171 +++++++++++++++++
 tb/tb_spi_addr_peripheral.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_addr_peripheral.sv
// SPI mode-0 slave in the sys_clk domain: first byte of each frame is an
// address, later bytes are data; a per-byte request fetches the next TX byte.
module spi_addr_peripheral #(
    parameter int BYTE_W = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              csn_pad,
    input  logic              sck_pad,
    input  logic              mosi_pad,
    output logic              miso_pad,
    input  logic              spi_data_written,
    input  logic [BYTE_W-1:0] spi_data_to_send,
    output logic [BYTE_W-1:0] spi_address_rx,
    output logic [BYTE_W-1:0] spi_data_byte_rx,
    output logic              spi_address_rx_valid,
    output logic              spi_data_byte_rx_valid,
    output logic              spi_dreq,
    output logic              valid_read,
    output logic [5:0]        byte_ctr
);
    localparam int CW = $clog2(BYTE_W);

    logic [2:0]        csn_sync_q, csn_sync_d;
    logic [2:0]        sck_sync_q, sck_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic              active_q, active_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic              done_q, done_d;
    logic [5:0]        byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              reload_q, reload_d;
    logic              miso_q, miso_d;
    logic [BYTE_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              addr_v_q, addr_v_d;
    logic              data_v_q, data_v_d;
    logic              dreq_q, dreq_d;
    logic              vr_q, vr_d;
    logic [5:0]        byte_ctr_q, byte_ctr_d;

    logic              csn_high, csn_fall, sck_rise, sck_fall;
    logic [BYTE_W-1:0] tx_src;

    assign csn_high = csn_sync_q[1];
    assign csn_fall = csn_sync_q[2] & ~csn_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    // A write in the same cycle as a load must win over the stale holding value.
    assign tx_src = spi_data_written ? spi_data_to_send : hold_q;

    always_comb begin
        csn_sync_d  = {csn_sync_q[1:0], csn_pad};
        sck_sync_d  = {sck_sync_q[1:0], sck_pad};
        mosi_sync_d = {mosi_sync_q[0], mosi_pad};
        active_d    = active_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        done_d      = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        tx_d        = tx_q;
        hold_d      = tx_src;
        reload_d    = reload_q;
        addr_d      = addr_q;
        data_d      = data_q;
        addr_v_d    = 1'b0;
        data_v_d    = 1'b0;
        dreq_d      = 1'b0;
        vr_d        = vr_q;
        byte_ctr_d  = byte_ctr_q;

        if (done_q) begin
            if (byte_cnt_q == 6'd0) begin
                addr_d   = rx_q;
                addr_v_d = 1'b1;
            end else begin
                data_d   = rx_q;
                data_v_d = 1'b1;
            end
            byte_ctr_d = byte_cnt_q;
            byte_cnt_d = (byte_cnt_q == 6'd63) ? byte_cnt_q : byte_cnt_q + 6'd1;
            dreq_d     = 1'b1;
            vr_d       = 1'b1;
            reload_d   = 1'b1;
        end

        if (csn_high) begin
            active_d = 1'b0;
            vr_d     = 1'b0;
        end else if (csn_fall) begin
            active_d   = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            byte_ctr_d = '0;
            tx_d       = tx_src;
            reload_d   = 1'b0;
        end else if (active_q) begin
            if (sck_rise) begin
                rx_d      = {rx_q[BYTE_W-2:0], mosi_sync_q[1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                done_d    = (bit_cnt_q == CW'(BYTE_W - 1));
                vr_d      = 1'b0;
            end
            if (sck_fall) begin
                if (reload_q) begin
                    tx_d     = tx_src;
                    reload_d = 1'b0;
                end else begin
                    tx_d = {tx_q[BYTE_W-2:0], 1'b0};
                end
            end
        end

        miso_d = active_d ? tx_d[BYTE_W-1] : 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            csn_sync_q  <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            active_q    <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            done_q      <= 1'b0;
            byte_cnt_q  <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            reload_q    <= 1'b0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            addr_v_q    <= 1'b0;
            data_v_q    <= 1'b0;
            dreq_q      <= 1'b0;
            vr_q        <= 1'b0;
            byte_ctr_q  <= '0;
        end else begin
            csn_sync_q  <= csn_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            active_q    <= active_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            done_q      <= done_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            reload_q    <= reload_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            addr_v_q    <= addr_v_d;
            data_v_q    <= data_v_d;
            dreq_q      <= dreq_d;
            vr_q        <= vr_d;
            byte_ctr_q  <= byte_ctr_d;
        end
    end

    assign miso_pad               = miso_q;
    assign spi_address_rx         = addr_q;
    assign spi_data_byte_rx       = data_q;
    assign spi_address_rx_valid   = addr_v_q;
    assign spi_data_byte_rx_valid = data_v_q;
    assign spi_dreq               = dreq_q;
    assign valid_read             = vr_q;
    assign byte_ctr               = byte_ctr_q;
endmodule

// File: tb/tb_spi_addr_peripheral.sv
// Bench for spi_addr_peripheral: SPI master model, receive scoreboard
// and a byte_ctr-driven response generator.
module tb_spi_addr_peripheral;
    localparam int HALF = 8;

    typedef struct {
        bit         is_addr;
        logic [7:0] val;
        logic [5:0] ctr;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       csn_pad = 1'b1;
    logic       sck_pad = 1'b0;
    logic       mosi_pad = 1'b0;
    logic       miso_pad;
    logic       spi_data_written;
    logic [7:0] spi_data_to_send;
    logic [7:0] spi_address_rx;
    logic [7:0] spi_data_byte_rx;
    logic       spi_address_rx_valid;
    logic       spi_data_byte_rx_valid;
    logic       spi_dreq;
    logic       valid_read;
    logic [5:0] byte_ctr;

    logic       loop_en = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic       resp_en = 1'b0;
    logic       resp_wr;
    logic [7:0] resp_data;

    int n_tests = 0;
    int n_fail = 0;
    int dreq_cnt = 0;
    int vr_cnt = 0;
    ev_t exp_q[$];

    assign spi_data_written = loop_en ? spi_dreq : resp_wr;
    assign spi_data_to_send = loop_en ? tb_data : resp_data;

    spi_addr_peripheral #(.BYTE_W(8)) dut (
        .sys_clk                (sys_clk),
        .rst                    (rst),
        .csn_pad                (csn_pad),
        .sck_pad                (sck_pad),
        .mosi_pad               (mosi_pad),
        .miso_pad               (miso_pad),
        .spi_data_written       (spi_data_written),
        .spi_data_to_send       (spi_data_to_send),
        .spi_address_rx         (spi_address_rx),
        .spi_data_byte_rx       (spi_data_byte_rx),
        .spi_address_rx_valid   (spi_address_rx_valid),
        .spi_data_byte_rx_valid (spi_data_byte_rx_valid),
        .spi_dreq               (spi_dreq),
        .valid_read             (valid_read),
        .byte_ctr               (byte_ctr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input bit a, input logic [7:0] v, input logic [5:0] c);
        ev_t e;
        e.is_addr = a;
        e.val     = v;
        e.ctr     = c;
        exp_q.push_back(e);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_pad = tx[7-i];
            repeat (HALF) @(negedge sys_clk);
            rx = {rx[6:0], miso_pad};
            sck_pad = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            sck_pad = 1'b0;
        end
    endtask

    task automatic send(input string nm, input logic [7:0] tx, input logic [7:0] exp_miso);
        logic [7:0] rx;
        xfer(tx, 8, rx);
        chk(nm, {24'h0, rx}, {24'h0, exp_miso});
    endtask

    task automatic frame_start();
        csn_pad = 1'b0;
        repeat (HALF) @(negedge sys_clk);
    endtask

    task automatic frame_stop();
        repeat (HALF) @(negedge sys_clk);
        csn_pad = 1'b1;
        repeat (2 * HALF) @(negedge sys_clk);
    endtask

    // Scoreboard monitor: every valid pulse consumes one expected event.
    initial begin
        ev_t e;
        logic vr_prev;
        vr_prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (spi_dreq) dreq_cnt++;
                if (valid_read && !vr_prev) vr_cnt++;
                if (spi_address_rx_valid || spi_data_byte_rx_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_kind", {31'h0, spi_address_rx_valid}, {31'h0, e.is_addr});
                        chk("ev_both", {31'h0, spi_address_rx_valid & spi_data_byte_rx_valid}, 32'd0);
                        chk("ev_val",
                            {24'h0, spi_address_rx_valid ? spi_address_rx : spi_data_byte_rx},
                            {24'h0, e.val});
                        chk("ev_ctr", {26'h0, byte_ctr}, {26'h0, e.ctr});
                    end
                end
            end
            vr_prev = rst ? 1'b0 : valid_read;
        end
    end

    // User logic choosing the next byte from byte_ctr on each valid_read rise.
    initial begin
        logic r_prev;
        r_prev    = 1'b0;
        resp_wr   = 1'b0;
        resp_data = 8'h00;
        forever begin
            @(negedge sys_clk);
            resp_wr = 1'b0;
            if (resp_en && valid_read && !r_prev) begin
                resp_wr   = 1'b1;
                resp_data = (byte_ctr == 6'd0) ? 8'hFF :
                            (byte_ctr == 6'd1) ? 8'h01 : 8'h00;
            end
            r_prev = valid_read;
        end
    end

    initial begin
        int d0;
        int v0;
        logic [7:0] junk;

        repeat (5) @(negedge sys_clk);
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_addr", {24'h0, spi_address_rx}, 32'h0);
        chk("rst_data", {24'h0, spi_data_byte_rx}, 32'h0);
        chk("rst_ctr", {26'h0, byte_ctr}, 32'h0);
        chk("rst_miso", {31'h0, miso_pad}, 32'h0);
        chk("rst_vr", {31'h0, valid_read}, 32'h0);
        chk("rst_dreq", {31'h0, spi_dreq}, 32'h0);
        repeat (2 * HALF) @(negedge sys_clk);

        // Address-only frame
        d0 = dreq_cnt;
        v0 = vr_cnt;
        expect_ev(1'b1, 8'hAA, 6'd0);
        frame_start();
        send("addr_miso", 8'hAA, 8'h00);
        frame_stop();
        chk("addr_out", {24'h0, spi_address_rx}, 32'hAA);
        chk("addr_dreq", dreq_cnt - d0, 32'd1);
        chk("addr_vr", vr_cnt - v0, 32'd1);
        chk("addr_pend", exp_q.size(), 32'd0);

        // Multi-byte frame with dreq looped back
        loop_en = 1'b1;
        tb_data = 8'h55;
        d0 = dreq_cnt;
        v0 = vr_cnt;
        expect_ev(1'b1, 8'h02, 6'd0);
        expect_ev(1'b0, 8'h11, 6'd1);
        expect_ev(1'b0, 8'h22, 6'd2);
        frame_start();
        send("multi_miso0", 8'h02, 8'h00);
        send("multi_miso1", 8'h11, 8'h55);
        send("multi_miso2", 8'h22, 8'h55);
        frame_stop();
        loop_en = 1'b0;
        chk("multi_addr", {24'h0, spi_address_rx}, 32'h02);
        chk("multi_data", {24'h0, spi_data_byte_rx}, 32'h22);
        chk("multi_ctr", {26'h0, byte_ctr}, 32'd2);
        chk("multi_dreq", dreq_cnt - d0, 32'd3);
        chk("multi_vr", vr_cnt - v0, 32'd3);
        chk("multi_vr_csn", {31'h0, valid_read}, 32'h0);
        chk("multi_pend", exp_q.size(), 32'd0);

        // Per-byte response chosen from byte_ctr
        resp_en = 1'b1;
        expect_ev(1'b1, 8'h10, 6'd0);
        expect_ev(1'b0, 8'h33, 6'd1);
        expect_ev(1'b0, 8'h44, 6'd2);
        frame_start();
        send("resp_miso0", 8'h10, 8'h55);
        send("resp_miso1", 8'h33, 8'hFF);
        send("resp_miso2", 8'h44, 8'h01);
        frame_stop();
        resp_en = 1'b0;
        chk("resp_pend", exp_q.size(), 32'd0);

        // Abort after 5 bits of a data byte
        expect_ev(1'b1, 8'h5A, 6'd0);
        frame_start();
        send("abort_miso0", 8'h5A, 8'h00);
        xfer(8'h77, 5, junk);
        frame_stop();
        chk("abort_addr", {24'h0, spi_address_rx}, 32'h5A);
        chk("abort_ctr", {26'h0, byte_ctr}, 32'd0);
        chk("abort_miso", {31'h0, miso_pad}, 32'h0);
        chk("abort_vr", {31'h0, valid_read}, 32'h0);
        expect_ev(1'b1, 8'hC3, 6'd0);
        frame_start();
        send("next_miso0", 8'hC3, 8'h00);
        frame_stop();
        chk("next_addr", {24'h0, spi_address_rx}, 32'hC3);
        chk("abort_pend", exp_q.size(), 32'd0);

        // Reset in the middle of byte 1
        expect_ev(1'b1, 8'h21, 6'd0);
        frame_start();
        send("mrst_miso0", 8'h21, 8'h00);
        xfer(8'h99, 3, junk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("mrst_addr", {24'h0, spi_address_rx}, 32'h0);
        chk("mrst_data", {24'h0, spi_data_byte_rx}, 32'h0);
        chk("mrst_ctr", {26'h0, byte_ctr}, 32'h0);
        chk("mrst_miso", {31'h0, miso_pad}, 32'h0);
        chk("mrst_vr", {31'h0, valid_read}, 32'h0);
        d0 = dreq_cnt;
        xfer(8'hFF, 5, junk);
        xfer(8'hA5, 8, junk);
        frame_stop();
        chk("mrst_ignored_addr", {24'h0, spi_address_rx}, 32'h0);
        chk("mrst_ignored_dreq", dreq_cnt - d0, 32'd0);
        expect_ev(1'b1, 8'h3C, 6'd0);
        expect_ev(1'b0, 8'h99, 6'd1);
        frame_start();
        send("post_miso0", 8'h3C, 8'h00);
        send("post_miso1", 8'h99, 8'h00);
        frame_stop();
        chk("post_addr", {24'h0, spi_address_rx}, 32'h3C);
        chk("post_data", {24'h0, spi_data_byte_rx}, 32'h99);
        chk("final_pend", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
